// File: rtl/dm_byteen_responder.sv
// Data-memory responder: combinational word reads, byte-lane-merged writes,
// hardware clear sweep after reset, sticky error flags and a commit counter.
module dm_byteen_responder #(
  parameter int unsigned DEPTH_WORDS    = 4096,
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        ready,
  output logic [1:0]  err,
  output logic [31:0] wr_count
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned LANES = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  logic [31:0]   mem [DEPTH_WORDS];

  state_t        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          ready_d;
  logic [1:0]    err_d;
  logic [31:0]   wr_count_d;

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   merged;

  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_wdata;

  // Address decode: base-relative offset, range check and word index.
  always_comb begin
    off      = m_data_addr - ADDR_BASE;
    in_range = ((off >> (AW + 2)) == 32'd0);
    idx      = off[AW+1:2];
  end

  // Current word at the decoded index and its byte-lane merge with the write data.
  always_comb begin
    rd_word = mem[idx];
    merged  = rd_word;
    for (int k = 0; k < LANES; k++) begin
      if (m_data_byteen[k]) begin
        merged[8*k +: 8] = m_data_wdata[8*k +: 8];
      end
    end
  end

  // Zero-latency read path; zero while sweeping or out of range.
  always_comb begin
    m_data_rdata = 32'h0;
    if ((state_q == ST_READY) && in_range) begin
      m_data_rdata = rd_word;
    end
  end

  // Next-state, sweep pointer, error, counter and array-write control.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    err_d      = err;
    wr_count_d = wr_count;
    mem_we     = 1'b0;
    mem_idx    = idx;
    mem_wdata  = merged;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = clr_ptr_q;
        mem_wdata = 32'h0;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = ST_READY;
        end
        // Any write attempt during the sweep is dropped and flagged.
        if (m_data_byteen != 4'b0000) begin
          err_d[1] = 1'b1;
        end
      end
      ST_READY: begin
        if (!in_range) begin
          err_d[0] = 1'b1;
        end else if (m_data_byteen != 4'b0000) begin
          mem_we     = 1'b1;
          wr_count_d = wr_count + 32'd1;
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase

    ready_d = (state_d == ST_READY);

    // Reset leaves the array untouched.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  // State and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RST_STATE;
      clr_ptr_q <= '0;
      ready     <= 1'b0;
      err       <= 2'b00;
      wr_count  <= 32'd0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready     <= ready_d;
      err       <= err_d;
      wr_count  <= wr_count_d;
    end
  end

  // Word array; written by the sweep or by accepted CPU writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_dm_byteen_responder.sv
// Directed self-checking bench for dm_byteen_responder (default parameters).
module tb_dm_byteen_responder;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic        ready;
  logic [1:0]  err;
  logic [31:0] wr_count;

  int n_checks;
  int n_errors;

  dm_byteen_responder dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata),
    .ready         (ready),
    .err           (err),
    .wr_count      (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One-cycle write, driven between negedges so exactly one posedge sees it.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    @(negedge clk);
    m_data_byteen = 4'b0000;
  endtask

  // Read sampled at a negedge with byteen idle.
  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    m_data_addr   = a;
    m_data_byteen = 4'b0000;
    #1;
    check(tag, m_data_rdata, exp);
  endtask

  // Counts posedges after reset release until ready, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 5000) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  int n;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    m_data_addr   = 32'h0;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'b0000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wr_count", wr_count, 32'd0);
    check("rst_rdata", m_data_rdata, 32'h0);

    // First sweep with a write attempt 10 cycles in (must be dropped)
    reset = 1'b0;
    n = 0;
    while (!ready && n < 5000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 10) begin
        m_data_addr   = 32'h40;
        m_data_wdata  = 32'hFFFF_FFFF;
        m_data_byteen = 4'b1111;
      end else if (n == 11) begin
        m_data_byteen = 4'b0000;
        check("clr_drop_err", 32'(err), 32'd2);
        check("clr_drop_wr_count", wr_count, 32'd0);
      end
    end
    check("sweep1_len", 32'(n), 32'd4096);
    read_chk("clr_drop_mem", 32'h40, 32'h0);
    check("clr_drop_err_sticky", 32'(err), 32'd2);

    // Preload word 5, then reset and verify the sweep erases it
    do_write(32'h14, 32'hDEAD_BEEF, 4'b1111);
    read_chk("preload_rd", 32'h14, 32'hDEAD_BEEF);
    check("preload_wr_count", wr_count, 32'd1);
    pulse_reset(2);
    wait_ready(n);
    check("sweep2_len", 32'(n), 32'd4096);
    read_chk("sweep2_mem5", 32'h14, 32'h0);
    check("sweep2_wr_count", wr_count, 32'd0);
    check("sweep2_err", 32'(err), 32'd0);

    // Byte merge with a non-contiguous mask
    do_write(32'h10, 32'h1122_3344, 4'b1111);
    do_write(32'h10, 32'hAABB_CCDD, 4'b0101);
    read_chk("merge_rd", 32'h13, 32'h11BB_33DD);
    check("merge_wr_count", wr_count, 32'd2);
    do_write(32'h10, 32'h0000_EE00, 4'b0010);
    read_chk("merge_lane1", 32'h10, 32'h11BB_EEDD);

    // Same-cycle read returns pre-write value
    @(negedge clk);
    m_data_addr   = 32'h20;
    m_data_wdata  = 32'hCAFE_F00D;
    m_data_byteen = 4'b1111;
    #1;
    check("rdw_old", m_data_rdata, 32'h0);
    @(negedge clk);
    m_data_byteen = 4'b0000;
    #1;
    check("rdw_new", m_data_rdata, 32'hCAFE_F00D);
    check("rdw_wr_count", wr_count, 32'd4);

    // Out-of-range write
    @(negedge clk);
    m_data_addr   = 32'h4000;
    m_data_wdata  = 32'h1234_5678;
    m_data_byteen = 4'b1111;
    #1;
    check("oor_rdata", m_data_rdata, 32'h0);
    check("oor_err_before", 32'(err), 32'd0);
    @(negedge clk);
    m_data_byteen = 4'b0000;
    check("oor_err", 32'(err), 32'd1);
    check("oor_wr_count", wr_count, 32'd4);
    read_chk("oor_word0", 32'h0, 32'h0);
    read_chk("top_word", 32'h3FFC, 32'h0);

    // Reset mid-sweep
    pulse_reset(1);
    repeat (2000) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_ready", 32'(ready), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
    end
    reset = 1'b0;
    wait_ready(n);
    check("sweep3_len", 32'(n), 32'd4096);
    check("sweep3_err", 32'(err), 32'd0);
    read_chk("sweep3_word4", 32'h10, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
